// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: state encoding,
// microsecond-to-cycle conversion and the frame parity rule.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_WAIT_CLK  = 3'd3,
    ST_SEND      = 3'd4,
    ST_ACK       = 3'd5,
    ST_WAIT_IDLE = 3'd6,
    ST_ABORT     = 3'd7
  } state_e;

  localparam int unsigned FRAME_BITS = 10;

  function automatic int unsigned us_to_cyc(input int unsigned clkfreq, input int unsigned us);
    return (clkfreq / 32'd1000000) * us;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // PS/2 uses odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, 3-sample stability filter and falling-edge
// detector for one PS/2 line. Pin-to-fall latency is 5 cycles.
module ps2_line_filter (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic [1:0] hist_q;
  logic       filt_q;
  logic       fall_q;

  // The filtered level only moves once three consecutive synchronized samples agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 2'b11;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[0], sync2_q};
      fall_q  <= 1'b0;
      if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) begin
        filt_q <= sync2_q;
        fall_q <= filt_q & ~sync2_q;
      end
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send and
// shifts one command byte out on device clock falls, then checks the device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLKFREQ          = 28000000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INHIBIT_CYC = us_to_cyc(CLKFREQ, INHIBIT_US);
  localparam int unsigned START_CYC   = us_to_cyc(CLKFREQ, START_TIMEOUT_US);
  localparam int unsigned FRAME_CYC   = us_to_cyc(CLKFREQ, FRAME_TIMEOUT_US);
  localparam int unsigned TMR_MAX     = max_u(START_CYC, FRAME_CYC);
  localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);
  localparam int unsigned INH_W       = $clog2(INHIBIT_CYC + 1);

  localparam logic [TMR_W-1:0] START_LD = TMR_W'(START_CYC);
  localparam logic [TMR_W-1:0] FRAME_LD = TMR_W'(FRAME_CYC);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);

  logic clk_filt_s, clk_fall_s;
  logic dat_filt_s, dat_fall_s;

  ps2_line_filter u_clk_filt (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2clk_in),
    .filt_o (clk_filt_s),
    .fall_o (clk_fall_s)
  );

  ps2_line_filter u_dat_filt (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2dat_in),
    .filt_o (dat_filt_s),
    .fall_o (dat_fall_s)
  );

  state_e                  state_q;
  logic                    clk_oe_q, dat_oe_q;
  logic                    busy_q, done_q, error_q;
  logic [INH_W-1:0]        inh_q;
  logic [TMR_W-1:0]        tmr_q;
  logic [3:0]              bit_idx_q;
  logic [3:0]              bit_idx_d;
  logic [FRAME_BITS-1:0]   shreg_q;

  assign bit_idx_d = bit_idx_q + 4'd1;

  // Transmit sequencer; every line driver and status flag is a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      inh_q     <= '0;
      tmr_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          if (start) begin
            shreg_q  <= {1'b1, odd_parity(data), data};
            busy_q   <= 1'b1;
            clk_oe_q <= 1'b1;
            inh_q    <= '0;
            state_q  <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inh_q == INH_LAST) begin
            dat_oe_q <= 1'b1;
            state_q  <= ST_RTS;
          end else begin
            inh_q <= inh_q + INH_W'(1);
          end
        end
        ST_RTS: begin
          clk_oe_q <= 1'b0;
          tmr_q    <= START_LD;
          state_q  <= ST_WAIT_CLK;
        end
        ST_WAIT_CLK: begin
          if (clk_fall_s) begin
            bit_idx_q <= '0;
            dat_oe_q  <= ~shreg_q[0];
            tmr_q     <= FRAME_LD;
            state_q   <= ST_SEND;
          end else if (tmr_q == '0) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            state_q  <= ST_ABORT;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_SEND: begin
          if (tmr_q == '0) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            state_q  <= ST_ABORT;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
            if (clk_fall_s) begin
              bit_idx_q <= bit_idx_d;
              dat_oe_q  <= ~shreg_q[bit_idx_d];
              if (bit_idx_d == 4'd9) begin
                state_q <= ST_ACK;
              end
            end
          end
        end
        ST_ACK: begin
          if (tmr_q == '0) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            state_q  <= ST_ABORT;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
            if (clk_fall_s) begin
              if (!dat_filt_s) begin
                state_q <= ST_WAIT_IDLE;
              end else begin
                clk_oe_q <= 1'b0;
                dat_oe_q <= 1'b0;
                state_q  <= ST_ABORT;
              end
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (tmr_q == '0) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            state_q  <= ST_ABORT;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
            if (clk_filt_s && dat_filt_s) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_ABORT: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          error_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  // The data-line fall is not needed by the transmitter; the receiver uses it.
  logic unused_s;
  assign unused_s = dat_fall_s;

  assign ps2clk_oe = clk_oe_q;
  assign ps2dat_oe = dat_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on the
// open-drain lines; timeouts are shortened through the module parameters.
module tb_ps2_host_tx;

  localparam int CLKFREQ = 28000000;
  localparam int INH_US  = 100;
  localparam int ST_US   = 500;
  localparam int FR_US   = 300;
  localparam int MHZ     = CLKFREQ / 1000000;
  localparam int INH     = MHZ * INH_US;
  localparam int TSTART  = MHZ * ST_US;
  localparam int TFRAME  = MHZ * FR_US;
  localparam int HALF    = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b0;
  logic       dev_dat = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ps2clk_oe, ps2dat_oe, busy, done, error;
  logic       clk_line, dat_line;

  assign clk_line = ~(ps2clk_oe | dev_clk);
  assign dat_line = ~(ps2dat_oe | dev_dat);

  ps2_host_tx #(
    .CLKFREQ          (CLKFREQ),
    .INHIBIT_US       (INH_US),
    .START_TIMEOUT_US (ST_US),
    .FRAME_TIMEOUT_US (FR_US)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2clk_in (clk_line),
    .ps2dat_in (dat_line),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .data      (data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, rel_cnt = 0;
  int low_run = 0, last_low_run = 0, last_err_cyc = 0, last_done_cyc = 0;

  // Observations of the last frame driven by drive_frame.
  logic [9:0] r_got;
  logic [1:0] r_oe;
  logic       r_sb, r_rel, r_end, r_busy;
  int         r_low, r_s0, r_f0, r_ecyc, r_ddone, r_derr;

  // Bus monitor: cycle count, done/error pulses and clock-low run lengths.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      last_done_cyc <= cyc + 1;
    end
    if (error) begin
      err_cnt <= err_cnt + 1;
      last_err_cyc <= cyc + 1;
    end
    if (!clk_line) low_run <= low_run + 1;
    else begin
      if (low_run > 0) begin
        last_low_run <= low_run;
        rel_cnt <= rel_cnt + 1;
      end
      low_run <= 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic model_parity(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // mode: 0 device ACKs, 1 device NACKs, 2 device silent, 3 device stalls after bit 4
  task automatic drive_frame(input logic [7:0] d, input int mode, input bit inj, input logic [7:0] d2);
    int r0, d0, e0, t, nf;
    d0 = done_cnt; e0 = err_cnt; r0 = rel_cnt;
    r_got = '0; r_rel = 1'b0; r_sb = 1'b1; r_low = 0; r_f0 = 0;
    r_s0 = cyc; start = 1'b1; data = d; tick(); start = 1'b0; data = 8'($urandom);
    if (inj) begin
      repeat (20) tick();
      start = 1'b1; data = d2; tick(); start = 1'b0;
    end
    t = 0;
    while (rel_cnt == r0 && t < INH + 100) begin tick(); t++; end
    if (rel_cnt != r0) begin r_rel = 1'b1; r_low = last_low_run; r_sb = dat_line; end
    if (mode == 2 || !r_rel) begin
      t = 0;
      while (err_cnt == e0 && done_cnt == d0 && t < TSTART + 200) begin tick(); t++; end
    end else begin
      repeat (10) tick();
      nf = (mode == 3) ? 5 : 10;
      for (int i = 0; i < nf; i++) begin
        dev_clk = 1'b1;
        if (i == 0) r_f0 = cyc;
        repeat (HALF) tick();
        dev_clk = 1'b0;
        repeat (HALF) tick();
        r_got[i] = dat_line;
      end
      if (mode == 3) begin
        t = 0;
        while (err_cnt == e0 && done_cnt == d0 && t < TFRAME + 200) begin tick(); t++; end
      end else begin
        dev_dat = (mode == 0);
        repeat (3) tick();
        dev_clk = 1'b1; repeat (HALF) tick();
        dev_clk = 1'b0; repeat (HALF) tick();
        dev_dat = 1'b0;
        t = 0;
        while (err_cnt == e0 && done_cnt == d0 && t < 300) begin tick(); t++; end
      end
    end
    r_end  = (err_cnt != e0) || (done_cnt != d0);
    r_ecyc = (err_cnt != e0) ? last_err_cyc : last_done_cyc;
    r_busy = busy;
    r_oe   = {ps2clk_oe, ps2dat_oe};
    repeat (10) tick();
    r_ddone = done_cnt - d0;
    r_derr  = err_cnt - e0;
    dev_clk = 1'b0; dev_dat = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({ps2clk_oe, ps2dat_oe, busy, done, error} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00000", {ps2clk_oe, ps2dat_oe, busy, done, error});
    end
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if ({ps2clk_oe, ps2dat_oe, busy} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got=%b want=000", {ps2clk_oe, ps2dat_oe, busy});
    end
  endtask

  task automatic test_frame_ack(input logic [7:0] d);
    drive_frame(d, 0, 1'b0, 8'h00);
    checks++;
    if (!r_rel || r_low < INH || r_low > INH + 3) begin
      errors++; $display("FAIL inhibit_%h low=%0d want=%0d..%0d", d, r_low, INH, INH + 3);
    end
    checks++;
    if (r_sb !== 1'b0) begin errors++; $display("FAIL start_bit_%h got=%b want=0", d, r_sb); end
    checks++;
    if (r_got[7:0] !== d) begin errors++; $display("FAIL data_bits_%h got=%h want=%h", d, r_got[7:0], d); end
    checks++;
    if (r_got[8] !== model_parity(d)) begin
      errors++; $display("FAIL parity_%h got=%b want=%b", d, r_got[8], model_parity(d));
    end
    checks++;
    if (r_got[9] !== 1'b1) begin errors++; $display("FAIL stop_bit_%h got=%b want=1", d, r_got[9]); end
    checks++;
    if (r_ddone != 1 || r_derr != 0) begin
      errors++; $display("FAIL done_pulse_%h done=%0d err=%0d want 1/0", d, r_ddone, r_derr);
    end
    checks++;
    if (!r_end || r_busy !== 1'b0) begin
      errors++; $display("FAIL busy_end_%h ended=%b busy=%b want 1/0", d, r_end, r_busy);
    end
  endtask

  task automatic test_start_timeout();
    int dt;
    drive_frame(8'hF4, 2, 1'b0, 8'h00);
    dt = r_ecyc - r_s0;
    checks++;
    if (!r_end || r_derr != 1 || r_ddone != 0) begin
      errors++; $display("FAIL start_timeout_pulse err=%0d done=%0d want 1/0", r_derr, r_ddone);
    end
    checks++;
    if (dt < INH + TSTART - 5 || dt > INH + TSTART + 5) begin
      errors++; $display("FAIL start_timeout_time got=%0d want=%0d+-5", dt, INH + TSTART);
    end
    checks++;
    if (r_oe !== 2'b00 || r_busy !== 1'b0) begin
      errors++; $display("FAIL start_timeout_release oe=%b busy=%b want 00/0", r_oe, r_busy);
    end
  endtask

  task automatic test_nack();
    drive_frame(8'hED, 1, 1'b0, 8'h00);
    checks++;
    if (r_derr != 1 || r_ddone != 0) begin
      errors++; $display("FAIL nack_error err=%0d done=%0d want 1/0", r_derr, r_ddone);
    end
    checks++;
    if (r_oe !== 2'b00 || r_busy !== 1'b0) begin
      errors++; $display("FAIL nack_release oe=%b busy=%b want 00/0", r_oe, r_busy);
    end
    test_frame_ack(8'hF4);
  endtask

  task automatic test_stall();
    int dt;
    drive_frame(8'h3C, 3, 1'b0, 8'h00);
    dt = r_ecyc - r_f0;
    checks++;
    if (!r_end || r_derr != 1 || r_ddone != 0) begin
      errors++; $display("FAIL stall_error err=%0d done=%0d want 1/0", r_derr, r_ddone);
    end
    checks++;
    if (dt < TFRAME - 5 || dt > TFRAME + 10) begin
      errors++; $display("FAIL stall_time got=%0d want=%0d..%0d", dt, TFRAME - 5, TFRAME + 10);
    end
    checks++;
    if (r_oe !== 2'b00 || r_busy !== 1'b0) begin
      errors++; $display("FAIL stall_release oe=%b busy=%b want 00/0", r_oe, r_busy);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d;
    d = 8'($urandom);
    drive_frame(d, 0, 1'b1, ~d);
    checks++;
    if (r_got[7:0] !== d || r_ddone != 1) begin
      errors++; $display("FAIL start_while_busy got=%h want=%h done=%0d", r_got[7:0], d, r_ddone);
    end
  endtask

  task automatic test_async_reset();
    int r0, t;
    bit stay;
    r0 = rel_cnt;
    start = 1'b1; data = 8'h55; tick(); start = 1'b0;
    t = 0;
    while (rel_cnt == r0 && t < INH + 100) begin tick(); t++; end
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b1; repeat (HALF) tick();
      if (i < 3) begin dev_clk = 1'b0; repeat (HALF) tick(); end
    end
    checks++;
    if (ps2dat_oe !== 1'b1) begin errors++; $display("FAIL bit3_driven got=%b want=1", ps2dat_oe); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ps2clk_oe, ps2dat_oe} !== 2'b00) begin
      errors++; $display("FAIL async_reset_release got=%b want=00", {ps2clk_oe, ps2dat_oe});
    end
    dev_clk = 1'b0;
    stay = 1'b1;
    repeat (5) begin
      tick();
      if (ps2clk_oe || ps2dat_oe || busy) stay = 1'b0;
    end
    checks++;
    if (!stay) begin errors++; $display("FAIL reset_hold got=released_lost want=held_released"); end
    rst = 1'b0;
    repeat (10) tick();
    test_frame_ack(8'hA7);
  endtask

  initial begin
    test_reset();
    test_frame_ack(8'hED);
    test_frame_ack(8'h01);
    test_frame_ack(8'hFF);
    for (int k = 0; k < 3; k++) test_frame_ack(8'($urandom));
    test_start_timeout();
    test_nack();
    test_stall();
    test_busy_ignore();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
